block_dispatcher: RTL and testbench

- Next-generation kernel launch unit. It replaces the static equal split of threads across cores with dynamic block-granular dispatch.
- Holds a COUNT_BITS-wide thread-count control register. Slices the kernel into blocks of THREADS_PER_BLOCK threads.
- Hands each block to the lowest-index free core over a start/done handshake, and recycles cores until every block has completed.
- Sits at GPU top level between the host control interface and the core array.

---
 rtl/block_dispatcher.sv | 150 +++++++++++++++
 tb/tb_block_dispatcher.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_dispatcher.sv
// Block-granular kernel dispatcher: slices the thread count into blocks and hands each one to the lowest free core.
// Define DISPATCH_PERF_COUNTERS_EN to build the saturating RUN-cycle counter on kernel_cycles.
module block_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int COUNT_BITS        = 16,
    localparam int TC_BITS          = $clog2(THREADS_PER_BLOCK + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic                            done,
    input  logic                            ctrl_write_enable,
    input  logic [COUNT_BITS-1:0]           ctrl_write_data,
    output logic [NUM_CORES-1:0]            core_start,
    output logic [NUM_CORES-1:0]            core_reset,
    output logic [NUM_CORES*COUNT_BITS-1:0] core_block_id,
    output logic [NUM_CORES*TC_BITS-1:0]    core_thread_count,
    input  logic [NUM_CORES-1:0]            core_done,
    output logic [COUNT_BITS-1:0]           blocks_done,
    output logic [31:0]                     kernel_cycles
);

    // state | meaning
    // IDLE  | thread_count writable, waiting for start
    // RUN   | dispatching blocks and collecting completions
    // DONE  | all blocks completed, waiting for start to drop
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int TPB_LOG2 = $clog2(THREADS_PER_BLOCK);
    localparam int CW       = COUNT_BITS + 1;

    state_t                 state;
    state_t                 state_next;
    logic [COUNT_BITS-1:0]  thread_count;
    logic [CW-1:0]          total_blocks;
    logic [CW-1:0]          blocks_dispatched;
    logic [CW-1:0]          total_calc;
    logic [CW-1:0]          remaining;
    logic [TC_BITS-1:0]     next_tc;
    logic [NUM_CORES-1:0]   completion;
    logic [NUM_CORES-1:0]   free_core;
    logic [NUM_CORES-1:0]   grant;
    logic [COUNT_BITS-1:0]  done_inc;
    logic                   found;
    logic                   dispatch;
    logic                   launch;
    logic                   all_done;

    // Extra bit keeps the round-up addition from wrapping at the maximum thread count.
    assign total_calc = ({1'b0, thread_count} + CW'(THREADS_PER_BLOCK - 1)) >> TPB_LOG2;
    assign remaining  = {1'b0, thread_count} - (blocks_dispatched << TPB_LOG2);
    assign next_tc    = (blocks_dispatched + CW'(1) == total_blocks) ? TC_BITS'(remaining)
                                                                    : TC_BITS'(THREADS_PER_BLOCK);
    assign launch     = (state == IDLE) && start;
    assign all_done   = ({1'b0, blocks_done} == total_blocks);
    assign completion = core_start & core_done & {NUM_CORES{state == RUN}};
    assign free_core  = ~core_start & ~core_reset;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (free_core[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        dispatch = (state == RUN) && found && (blocks_dispatched < total_blocks);
    end

    always_comb begin
        done_inc = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            done_inc = done_inc + COUNT_BITS'(completion[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (all_done) state_next = DONE;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thread_count      <= '0;
            total_blocks      <= '0;
            blocks_dispatched <= '0;
            blocks_done       <= '0;
            core_start        <= '0;
            core_reset        <= '0;
            core_block_id     <= '0;
            core_thread_count <= '0;
        end else begin
            if ((state == IDLE) && ctrl_write_enable) begin
                thread_count <= ctrl_write_data;
            end
            core_reset <= completion;
            if (launch) begin
                total_blocks      <= total_calc;
                blocks_dispatched <= '0;
                blocks_done       <= '0;
            end else if (state == RUN) begin
                blocks_done <= blocks_done + done_inc;
                if (dispatch) begin
                    blocks_dispatched <= blocks_dispatched + CW'(1);
                end
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (completion[i]) begin
                    core_start[i] <= 1'b0;
                end else if (dispatch && grant[i]) begin
                    core_start[i]                               <= 1'b1;
                    core_block_id[i*COUNT_BITS +: COUNT_BITS]   <= blocks_dispatched[COUNT_BITS-1:0];
                    core_thread_count[i*TC_BITS +: TC_BITS]     <= next_tc;
                end
            end
        end
    end

`ifdef DISPATCH_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            kernel_cycles <= '0;
        end else if ((state == RUN) && (kernel_cycles != '1)) begin
            kernel_cycles <= kernel_cycles + 32'd1;
        end
    end
`else
    assign kernel_cycles = '0;
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Testbench for block_dispatcher: directed scenarios plus randomized kernels checked against an event-level core model.
module tb_block_dispatcher;

    localparam int NC  = 2;
    localparam int TPB = 4;
    localparam int CB  = 16;
    localparam int TCB = $clog2(TPB + 1);
`ifdef DISPATCH_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              done;
    logic              ctrl_write_enable;
    logic [CB-1:0]     ctrl_write_data;
    logic [NC-1:0]     core_start;
    logic [NC-1:0]     core_reset;
    logic [NC*CB-1:0]  core_block_id;
    logic [NC*TCB-1:0] core_thread_count;
    logic [NC-1:0]     core_done;
    logic [CB-1:0]     blocks_done;
    logic [31:0]       kernel_cycles;

    int checks = 0;
    int passes = 0;

    block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .COUNT_BITS(CB)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .ctrl_write_enable(ctrl_write_enable), .ctrl_write_data(ctrl_write_data),
        .core_start(core_start), .core_reset(core_reset), .core_block_id(core_block_id),
        .core_thread_count(core_thread_count), .core_done(core_done),
        .blocks_done(blocks_done), .kernel_cycles(kernel_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_tc(input int value);
        ctrl_write_enable = 1'b1;
        ctrl_write_data   = CB'(value);
        tick();
        ctrl_write_enable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ctrl_write_enable = 1'b0; ctrl_write_data = '0; core_done = '0;
        tick(); tick();
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passes++;
        checks++; if (core_start !== 2'b00) $display("FAIL reset_core_start: got %b expected 00", core_start); else passes++;
        checks++; if (core_reset !== 2'b00) $display("FAIL reset_core_reset: got %b expected 00", core_reset); else passes++;
        checks++; if (blocks_done !== 16'd0) $display("FAIL reset_blocks_done: got %0d expected 0", blocks_done); else passes++;
        checks++; if (kernel_cycles !== 32'd0) $display("FAIL reset_kernel_cycles: got %0d expected 0", kernel_cycles); else passes++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_even_split();
        write_tc(8);
        start = 1'b1;
        tick();
        checks++; if (core_start !== 2'b00) $display("FAIL even_first_run_cycle: got %b expected 00", core_start); else passes++;
        tick();
        checks++; if (core_start !== 2'b01 || core_block_id[0 +: CB] !== 16'd0 || core_thread_count[0 +: TCB] !== 3'd4)
            $display("FAIL even_dispatch0: got start %b id %0d cnt %0d expected 01/0/4", core_start, core_block_id[0 +: CB], core_thread_count[0 +: TCB]);
        else passes++;
        tick();
        checks++; if (core_start !== 2'b11 || core_block_id[CB +: CB] !== 16'd1 || core_thread_count[TCB +: TCB] !== 3'd4)
            $display("FAIL even_dispatch1: got start %b id %0d cnt %0d expected 11/1/4", core_start, core_block_id[CB +: CB], core_thread_count[TCB +: TCB]);
        else passes++;
        core_done = 2'b11;
        tick();
        core_done = 2'b00;
        checks++; if (core_start !== 2'b00 || core_reset !== 2'b11 || blocks_done !== 16'd2 || done !== 1'b0)
            $display("FAIL even_dual_complete: got start %b rst %b bd %0d done %b expected 00/11/2/0", core_start, core_reset, blocks_done, done);
        else passes++;
        tick();
        checks++; if (core_reset !== 2'b00 || done !== 1'b1 || blocks_done !== 16'd2)
            $display("FAIL even_done: got rst %b done %b bd %0d expected 00/1/2", core_reset, done, blocks_done);
        else passes++;
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b0) $display("FAIL even_idle_return: got %b expected 0", done); else passes++;
    endtask

    task automatic test_uneven_and_ctrl_write();
        write_tc(10);
        start = 1'b1;
        tick(); tick();
        checks++; if (core_start !== 2'b01 || core_block_id[0 +: CB] !== 16'd0 || core_thread_count[0 +: TCB] !== 3'd4)
            $display("FAIL uneven_dispatch0: got start %b id %0d cnt %0d expected 01/0/4", core_start, core_block_id[0 +: CB], core_thread_count[0 +: TCB]);
        else passes++;
        ctrl_write_enable = 1'b1; ctrl_write_data = 16'd100;
        tick();
        ctrl_write_enable = 1'b0;
        checks++; if (core_start !== 2'b11 || core_block_id[CB +: CB] !== 16'd1)
            $display("FAIL uneven_dispatch1: got start %b id %0d expected 11/1", core_start, core_block_id[CB +: CB]);
        else passes++;
        core_done = 2'b10;
        tick();
        core_done = 2'b00;
        checks++; if (core_start !== 2'b01 || core_reset !== 2'b10 || blocks_done !== 16'd1)
            $display("FAIL uneven_core1_complete: got start %b rst %b bd %0d expected 01/10/1", core_start, core_reset, blocks_done);
        else passes++;
        tick();
        checks++; if (core_start !== 2'b01 || core_reset !== 2'b00)
            $display("FAIL uneven_pulse_gap: got start %b rst %b expected 01/00", core_start, core_reset);
        else passes++;
        tick();
        checks++; if (core_start !== 2'b11 || core_block_id[CB +: CB] !== 16'd2 || core_thread_count[TCB +: TCB] !== 3'd2)
            $display("FAIL uneven_last_block: got start %b id %0d cnt %0d expected 11/2/2", core_start, core_block_id[CB +: CB], core_thread_count[TCB +: TCB]);
        else passes++;
        core_done = 2'b11;
        tick();
        core_done = 2'b00;
        checks++; if (blocks_done !== 16'd3 || core_reset !== 2'b11)
            $display("FAIL uneven_final_complete: got bd %0d rst %b expected 3/11", blocks_done, core_reset);
        else passes++;
        tick();
        checks++; if (done !== 1'b1) $display("FAIL uneven_done: got %b expected 1", done); else passes++;
        start = 1'b0;
        tick();
    endtask

    task automatic test_zero_blocks();
        write_tc(0);
        start = 1'b1;
        tick();
        checks++; if (done !== 1'b0 || core_start !== 2'b00) $display("FAIL zero_run: got done %b start %b expected 0/00", done, core_start); else passes++;
        tick();
        checks++; if (done !== 1'b1 || core_start !== 2'b00) $display("FAIL zero_done: got done %b start %b expected 1/00", done, core_start); else passes++;
        tick();
        checks++; if (done !== 1'b1) $display("FAIL zero_hold: got %b expected 1", done); else passes++;
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b0) $display("FAIL zero_release: got %b expected 0", done); else passes++;
    endtask

    task automatic test_reset_mid_run();
        write_tc(16);
        start = 1'b1;
        tick(); tick(); tick();
        checks++; if (core_start !== 2'b11) $display("FAIL midreset_pre: got %b expected 11", core_start); else passes++;
        reset = 1'b1;
        tick();
        checks++; if (core_start !== 2'b00 || core_reset !== 2'b00 || done !== 1'b0 || blocks_done !== 16'd0)
            $display("FAIL midreset_clear: got start %b rst %b done %b bd %0d expected 00/00/0/0", core_start, core_reset, done, blocks_done);
        else passes++;
        reset = 1'b0;
        tick(); tick();
        checks++; if (done !== 1'b1 || core_start !== 2'b00)
            $display("FAIL midreset_register_cleared: got done %b start %b expected 1/00", done, core_start);
        else passes++;
        start = 1'b0;
        tick();
    endtask

    task automatic test_perf_counter();
        int cyc;
        int exp_kc;
        write_tc(4);
        start = 1'b1;
        cyc = 0;
        while (core_start[0] !== 1'b1 && cyc < 10) begin tick(); cyc++; end
        checks++; if (core_start[0] !== 1'b1 || cyc != 2)
            $display("FAIL perf_dispatch: got start %b after %0d cycles expected 1 after 2", core_start[0], cyc);
        else passes++;
        repeat (4) begin tick(); cyc++; end
        core_done = 2'b01;
        tick(); cyc++;
        core_done = 2'b00;
        while (done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        checks++; if (done !== 1'b1 || cyc != 8) $display("FAIL perf_done_time: got done %b at %0d expected 1 at 8", done, cyc); else passes++;
        exp_kc = PERF ? cyc - 1 : 0;
        checks++; if (kernel_cycles !== 32'(exp_kc)) $display("FAIL perf_cycles: got %0d expected %0d", kernel_cycles, exp_kc); else passes++;
        repeat (3) tick();
        checks++; if (kernel_cycles !== 32'(exp_kc)) $display("FAIL perf_hold_done: got %0d expected %0d", kernel_cycles, exp_kc); else passes++;
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b0 || kernel_cycles !== 32'(exp_kc))
            $display("FAIL perf_hold_idle: got done %b kc %0d expected 0/%0d", done, kernel_cycles, exp_kc);
        else passes++;
    endtask

    // Each core is modelled as an agent that accepts a block, works for a random time, then reports done.
    task automatic test_random_kernels(input int n_kernels);
        for (int k = 0; k < n_kernels; k++) begin
            int tc, total, next_id, completed, cyc, reach, exp_cnt;
            int lat [NC];
            bit busy [NC];
            logic [NC-1:0] prev_start, prev_free, rise, exp_rise;
            bit prev_remaining;
            int errs;
            tc = $urandom_range(0, 40);
            total = (tc + TPB - 1) / TPB;
            write_tc(tc);
            start = 1'b1;
            prev_start = '0; prev_free = '0; prev_remaining = 1'b0;
            next_id = 0; completed = 0; reach = -1; errs = 0;
            for (int i = 0; i < NC; i++) begin busy[i] = 1'b0; lat[i] = 0; end
            tick();
            cyc = 1;
            while (done !== 1'b1 && cyc < 500) begin
                rise = core_start & ~prev_start;
                exp_rise = '0;
                if (prev_remaining) begin
                    for (int i = NC - 1; i >= 0; i--) if (prev_free[i]) exp_rise = NC'(1) << i;
                end
                if (rise !== exp_rise) begin
                    errs++;
                    $display("FAIL rand_dispatch_choice: kernel %0d cycle %0d got %b expected %b", k, cyc, rise, exp_rise);
                end
                for (int i = 0; i < NC; i++) begin
                    if (busy[i] && !core_start[i]) begin
                        busy[i] = 1'b0;
                        completed++;
                        if (core_reset[i] !== 1'b1) begin errs++; $display("FAIL rand_reset_pulse: core %0d got 0 expected 1", i); end
                    end else if (core_reset[i] !== 1'b0) begin
                        errs++; $display("FAIL rand_spurious_reset: core %0d got 1 expected 0", i);
                    end
                    if (rise[i]) begin
                        exp_cnt = (tc - TPB * next_id < TPB) ? tc - TPB * next_id : TPB;
                        if (core_block_id[i*CB +: CB] !== CB'(next_id) || core_thread_count[i*TCB +: TCB] !== TCB'(exp_cnt)) begin
                            errs++;
                            $display("FAIL rand_block: core %0d got id %0d cnt %0d expected %0d/%0d", i,
                                     core_block_id[i*CB +: CB], core_thread_count[i*TCB +: TCB], next_id, exp_cnt);
                        end
                        next_id++;
                        busy[i] = 1'b1;
                        lat[i] = $urandom_range(0, 6);
                    end
                end
                if (blocks_done !== CB'(completed)) begin
                    errs++; $display("FAIL rand_blocks_done: got %0d expected %0d", blocks_done, completed);
                end
                if (kernel_cycles !== (PERF ? 32'(cyc - 1) : 32'd0)) begin
                    errs++; $display("FAIL rand_kernel_cycles: got %0d expected %0d", kernel_cycles, PERF ? cyc - 1 : 0);
                end
                if (completed == total && reach < 0) reach = cyc;
                prev_start = core_start;
                prev_free = ~core_start & ~core_reset;
                prev_remaining = (next_id < total);
                for (int i = 0; i < NC; i++) begin
                    if (busy[i]) begin
                        if (lat[i] == 0) core_done[i] = 1'b1;
                        else begin core_done[i] = 1'b0; lat[i]--; end
                    end else begin
                        core_done[i] = 1'($urandom_range(0, 1));
                    end
                end
                ctrl_write_enable = 1'($urandom_range(0, 1));
                ctrl_write_data = CB'($urandom);
                tick();
                cyc++;
            end
            ctrl_write_enable = 1'b0;
            core_done = '0;
            checks++; if (done !== 1'b1) $display("FAIL rand_timeout: kernel %0d tc %0d done %b expected 1", k, tc, done); else passes++;
            checks++; if (errs != 0) $display("FAIL rand_cycle_checks: kernel %0d got %0d errors expected 0", k, errs); else passes++;
            checks++; if (next_id != total || blocks_done !== CB'(total))
                $display("FAIL rand_totals: kernel %0d dispatched %0d bd %0d expected %0d", k, next_id, blocks_done, total);
            else passes++;
            checks++; if (cyc != reach + 1) $display("FAIL rand_done_latency: kernel %0d done at %0d expected %0d", k, cyc, reach + 1); else passes++;
            tick();
            checks++; if (done !== 1'b1 || core_start !== 2'b00) $display("FAIL rand_done_hold: got done %b start %b expected 1/00", done, core_start); else passes++;
            start = 1'b0;
            tick();
            checks++; if (done !== 1'b0) $display("FAIL rand_release: got %b expected 0", done); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_even_split();
        test_uneven_and_ctrl_write();
        test_zero_blocks();
        test_reset_mid_run();
        test_perf_counter();
        test_random_kernels(25);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
